// File: rtl/jpeg_dec_d1_pixout_qout_pkg.sv
// Shared definitions for the decoder page output queues: token layout,
// pack/unpack helpers and the default queue geometry.
package jpeg_dec_d1_pixout_qout_pkg;

  localparam int TOKEN_W       = 9;
  localparam int DEFAULT_DEPTH = 4;
  localparam int DEFAULT_SLACK = 1;

  typedef logic [TOKEN_W-1:0] token_t;

  // Token layout is {d[7:0], e}
  function automatic token_t pack_token(input logic [7:0] d, input logic e);
    return {d, e};
  endfunction

  function automatic logic [7:0] token_data(input token_t t);
    return t[TOKEN_W-1:1];
  endfunction

  function automatic logic token_eos(input token_t t);
    return t[0];
  endfunction

endpackage

// File: rtl/jpeg_dec_d1_pixout_qout_if.sv
// v/b token stream link: data, end-of-stream flag, valid and backpressure.
interface jpeg_dec_d1_pixout_qout_if;
  logic [7:0] d;
  logic       e;
  logic       v;
  logic       b;

  modport master (output d, output e, output v, input b);
  modport slave  (input d, input e, input v, output b);
endinterface

// File: rtl/jpeg_dec_d1_pixout_qout_q_fifo_sync.sv
// Generic single-clock circular buffer with occupancy count, full and empty.
// Storage is not reset; only pointers and count are.
module q_fifo_sync #(
  parameter int WIDTH = 9,
  parameter int DEPTH = 4
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           wdata,
  output logic [WIDTH-1:0]           rdata,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    wptr_r;
  logic [AW-1:0]    rptr_r;
  logic [CW-1:0]    count_r;
  logic             do_push_s;
  logic             do_pop_s;

  // Qualify requests: never pop empty, never push full unless a pop frees a slot
  always_comb begin
    do_pop_s  = pop && (count_r != CW'(0));
    do_push_s = push && ((count_r != CW'(DEPTH)) || do_pop_s);
  end

  // Storage write port
  always_ff @(posedge clock) begin
    if (do_push_s) begin
      mem_r[wptr_r] <= wdata;
    end
  end

  // Pointer and occupancy state; DEPTH is a power of two so pointers wrap naturally
  always_ff @(posedge clock) begin
    if (reset) begin
      wptr_r  <= AW'(0);
      rptr_r  <= AW'(0);
      count_r <= CW'(0);
    end else begin
      if (do_push_s) begin
        wptr_r <= wptr_r + AW'(1);
      end
      if (do_pop_s) begin
        rptr_r <= rptr_r + AW'(1);
      end
      case ({do_push_s, do_pop_s})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Status and head-of-queue read
  always_comb begin
    rdata = mem_r[rptr_r];
    count = count_r;
    full  = (count_r == CW'(DEPTH));
    empty = (count_r == CW'(0));
  end

endmodule

// File: rtl/jpeg_dec_d1_pixout_qout.sv
// Inter-page output queue: buffers the page's token stream toward the consumer,
// raising backpressure SLACK entries early and flagging overflow drops.
module jpeg_dec_d1_pixout_qout
  import jpeg_dec_d1_pixout_qout_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH,
  parameter int SLACK = DEFAULT_SLACK
) (
  input  logic                             clock,
  input  logic                             reset,
  jpeg_dec_d1_pixout_qout_if.slave         qin,
  jpeg_dec_d1_pixout_qout_if.master        qout,
  output logic                             ovf
);

  localparam int              CW     = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0]   THRESH = CW'(DEPTH - SLACK);

  token_t          wdata_s;
  token_t          rdata_s;
  logic [CW-1:0]   count_s;
  logic            full_s;
  logic            empty_s;
  logic            push_s;
  logic            pop_s;
  logic            drop_s;
  logic            ovf_r;

  // Push/pop decode; qin_b never gates a push, only a truly full queue drops
  always_comb begin
    pop_s   = !empty_s && !qout.b;
    drop_s  = qin.v && full_s && !pop_s;
    push_s  = qin.v && !drop_s;
    wdata_s = pack_token(qin.d, qin.e);
  end

  q_fifo_sync #(
    .WIDTH (TOKEN_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clock (clock),
    .reset (reset),
    .push  (push_s),
    .pop   (pop_s),
    .wdata (wdata_s),
    .rdata (rdata_s),
    .count (count_s),
    .full  (full_s),
    .empty (empty_s)
  );

  // Sticky overflow flag, cleared only by reset
  always_ff @(posedge clock) begin
    if (reset) begin
      ovf_r <= 1'b0;
    end else if (drop_s) begin
      ovf_r <= 1'b1;
    end else begin
      ovf_r <= ovf_r;
    end
  end

  // Stream port mapping; everything here depends on registered state only
  always_comb begin
    qin.b  = (count_s >= THRESH);
    qout.v = !empty_s;
    qout.d = token_data(rdata_s);
    qout.e = token_eos(rdata_s);
    ovf    = ovf_r;
  end

endmodule

// File: tb/tb_jpeg_dec_d1_pixout_qout.sv
// Directed plus randomized bench for the page output queue, checked against a
// queue-based reference model of the token stream.
module tb_jpeg_dec_d1_pixout_qout;

  localparam int DEPTH = 4;
  localparam int SLACK = 1;

  logic clock = 1'b0;
  logic reset;
  logic ovf;

  jpeg_dec_d1_pixout_qout_if qin_bus ();
  jpeg_dec_d1_pixout_qout_if qout_bus ();

  jpeg_dec_d1_pixout_qout #(
    .DEPTH (DEPTH),
    .SLACK (SLACK)
  ) dut (
    .clock (clock),
    .reset (reset),
    .qin   (qin_bus),
    .qout  (qout_bus),
    .ovf   (ovf)
  );

  always #5 clock = ~clock;

  int          n_cmp = 0;
  int          n_err = 0;
  logic [8:0]  model_q[$];
  logic        model_ovf;
  logic [7:0]  popped[$];

  task automatic cmp(input string tag, input logic [8:0] obs, input logic [8:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check(input string tag);
    logic exp_v;
    exp_v = (model_q.size() != 0);
    cmp({tag, ".qout_v"}, 9'(qout_bus.v), 9'(exp_v));
    cmp({tag, ".qin_b"}, 9'(qin_bus.b), 9'(model_q.size() >= DEPTH - SLACK));
    cmp({tag, ".ovf"}, 9'(ovf), 9'(model_ovf));
    if (exp_v) begin
      cmp({tag, ".qout_d"}, 9'(qout_bus.d), 9'(model_q[0][8:1]));
      cmp({tag, ".qout_e"}, 9'(qout_bus.e), 9'(model_q[0][0]));
    end
  endtask

  // One clock of stimulus; the model advances on the state seen before the edge
  task automatic cycle(input logic v, input logic [7:0] d, input logic e,
                       input logic b, input string tag);
    logic pop;
    qin_bus.v  = v;
    qin_bus.d  = d;
    qin_bus.e  = e;
    qout_bus.b = b;
    pop = (model_q.size() != 0) && !b;
    if (pop) popped.push_back(model_q[0][8:1]);
    if (v && model_q.size() == DEPTH && !pop) begin
      model_ovf = 1'b1;
    end else begin
      if (pop) void'(model_q.pop_front());
      if (v) model_q.push_back({d, e});
    end
    @(posedge clock);
    #1;
    check(tag);
  endtask

  task automatic do_reset(input string tag);
    reset      = 1'b1;
    qin_bus.v  = 1'b0;
    qin_bus.d  = 8'h00;
    qin_bus.e  = 1'b0;
    @(posedge clock);
    #1;
    reset = 1'b0;
    model_q.delete();
    model_ovf = 1'b0;
    check(tag);
  endtask

  initial begin
    logic [7:0] exp_pop [5];
    int         sent;
    qout_bus.b = 1'b0;
    model_ovf  = 1'b0;
    do_reset("reset0");
    do_reset("reset1");

    // Four tokens in order, EOS on the last, each visible one cycle after push
    cycle(1'b1, 8'h11, 1'b0, 1'b0, "seq11");
    cycle(1'b1, 8'h22, 1'b0, 1'b0, "seq22");
    cycle(1'b1, 8'h33, 1'b0, 1'b0, "seq33");
    cycle(1'b1, 8'h44, 1'b1, 1'b0, "seq44");
    for (int i = 0; i < 3; i++) cycle(1'b0, 8'h00, 1'b0, 1'b0, "drain1");

    // Early backpressure, fill to DEPTH, then overflow drop
    do_reset("reset2");
    popped.delete();
    cycle(1'b1, 8'hA1, 1'b0, 1'b1, "fill1");
    cycle(1'b1, 8'hA2, 1'b0, 1'b1, "fill2");
    cycle(1'b1, 8'hA3, 1'b0, 1'b1, "fill3");
    cmp("qin_b_after_3rd", 9'(qin_bus.b), 9'd1);
    cycle(1'b1, 8'hA4, 1'b0, 1'b1, "fill4");
    cmp("ovf_at_full", 9'(ovf), 9'd0);
    cycle(1'b1, 8'hEE, 1'b1, 1'b1, "overflow");
    cmp("ovf_after_drop", 9'(ovf), 9'd1);
    cmp("head_after_drop", 9'(qout_bus.d), 9'h0A1);
    // Push and pop on a full queue
    cycle(1'b1, 8'hB0, 1'b0, 1'b0, "full_pushpop");
    cmp("head_advanced", 9'(qout_bus.d), 9'h0A2);
    for (int i = 0; i < 6; i++) cycle(1'b0, 8'h00, 1'b0, 1'b0, "drain2");
    exp_pop = '{8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hB0};
    cmp("drain2_count", 9'(popped.size()), 9'd5);
    for (int i = 0; i < 5 && i < popped.size(); i++)
      cmp($sformatf("drain2_tok%0d", i), 9'(popped[i]), 9'(exp_pop[i]));

    // Alternating stall with producer honouring qin_b, 16 tokens, pointer wrap
    do_reset("reset3");
    popped.delete();
    sent = 0;
    for (int c = 0; c < 200 && (sent < 16 || model_q.size() != 0); c++) begin
      logic vv;
      vv = (sent < 16) && !qin_bus.b;
      cycle(vv, 8'(sent), 1'b0, c[0], "alt");
      if (vv) sent++;
    end
    cmp("alt_sent", 9'(sent), 9'd16);
    cmp("alt_recv", 9'(popped.size()), 9'd16);
    for (int i = 0; i < 16 && i < popped.size(); i++)
      cmp($sformatf("alt_tok%0d", i), 9'(popped[i]), 9'(i));

    // Randomized traffic, overflow allowed
    for (int c = 0; c < 400; c++)
      cycle($urandom_range(0, 3) != 0, 8'($urandom), 1'($urandom),
            $urandom_range(0, 2) == 0, "rand");

    // Mid-stream reset discards queued tokens
    do_reset("reset4");
    cycle(1'b1, 8'h01, 1'b0, 1'b1, "load1");
    cycle(1'b1, 8'h02, 1'b0, 1'b1, "load2");
    cycle(1'b1, 8'h03, 1'b1, 1'b1, "load3");
    qout_bus.b = 1'b0;
    do_reset("midreset");
    cmp("midreset_v", 9'(qout_bus.v), 9'd0);
    cmp("midreset_b", 9'(qin_bus.b), 9'd0);
    cycle(1'b1, 8'hA5, 1'b0, 1'b0, "after_reset");
    cmp("first_after_reset", 9'(qout_bus.d), 9'h0A5);
    cycle(1'b0, 8'h00, 1'b0, 1'b0, "final_drain");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
